// File: rtl/inst_fetch_if.sv
// Fetch-side bus: memory port A plus the decode valid/ready handshake and redirect.
// The halted status wire exists only when built with IFETCH_HALT_EN.
interface inst_fetch_if #(
  parameter int DATA = 18,
  parameter int ADDR = 14
);
  logic [ADDR-1:0] mem_addr;
  logic            mem_wr;
  logic [DATA-1:0] mem_din;
  logic [DATA-1:0] mem_dout;
  logic            redirect;
  logic [ADDR-1:0] redirect_addr;
  logic            inst_valid;
  logic            inst_ready;
  logic [DATA-1:0] inst;
  logic [ADDR-1:0] inst_pc;
`ifdef IFETCH_HALT_EN
  logic            halted;
`endif

  modport master (
    output mem_addr, mem_wr, mem_din, inst_valid, inst, inst_pc,
`ifdef IFETCH_HALT_EN
    output halted,
`endif
    input  mem_dout, redirect, redirect_addr, inst_ready
  );

  modport slave (
    input  mem_addr, mem_wr, mem_din, inst_valid, inst, inst_pc,
`ifdef IFETCH_HALT_EN
    input  halted,
`endif
    output mem_dout, redirect, redirect_addr, inst_ready
  );
endinterface

// File: rtl/inst_fetch.sv
// Instruction fetch: sequential PC, one in-flight read, 2-entry output queue, redirect flush.
// Optional feature IFETCH_HALT_EN stops fetching after HALT_WORD is received.
module inst_fetch #(
  parameter int              DATA      = 18,
  parameter int              ADDR      = 14,
  parameter logic [ADDR-1:0] RESET_PC  = '0
`ifdef IFETCH_HALT_EN
  ,
  parameter logic [DATA-1:0] HALT_WORD = '1
`endif
) (
  input  logic          clk,
  input  logic          rst,
  inst_fetch_if.master  bus
);

  logic [ADDR-1:0] r_pc;
  logic            r_inflight;
  logic [ADDR-1:0] r_inflight_pc;
  logic [1:0]      r_count;
  logic            r_valid;
  logic [DATA-1:0] r_q_inst [2];
  logic [ADDR-1:0] r_q_pc   [2];
  logic            r_halted;

  logic            w_pop;
  logic            w_push;
  logic            w_issue;
  logic [2:0]      w_credit;
  logic [1:0]      w_count_nxt;
  logic [DATA-1:0] w_q0_inst_nxt;
  logic [ADDR-1:0] w_q0_pc_nxt;
  logic [DATA-1:0] w_q1_inst_nxt;
  logic [ADDR-1:0] w_q1_pc_nxt;

  assign w_pop    = r_valid & bus.inst_ready;
  // Slots already committed (queued + in flight) minus the one leaving this cycle.
  assign w_credit = {1'b0, r_count} + {2'b00, r_inflight} - {2'b00, w_pop};

`ifdef IFETCH_HALT_EN
  assign w_issue  = !bus.redirect && (w_credit < 3'd2) && !r_halted;
  assign w_push   = r_inflight && !bus.redirect && !r_halted;
`else
  assign w_issue  = !bus.redirect && (w_credit < 3'd2);
  assign w_push   = r_inflight && !bus.redirect;
`endif

  assign bus.mem_addr   = r_pc;
  assign bus.mem_wr     = 1'b0;
  assign bus.mem_din    = '0;
  assign bus.inst_valid = r_valid;
  assign bus.inst       = r_q_inst[0];
  assign bus.inst_pc    = r_q_pc[0];
`ifdef IFETCH_HALT_EN
  assign bus.halted     = r_halted;
`endif

  // Queue next state: entry 0 is always the head, entry 1 shifts down on pop.
  always_comb begin
    w_count_nxt   = r_count;
    w_q0_inst_nxt = r_q_inst[0];
    w_q0_pc_nxt   = r_q_pc[0];
    w_q1_inst_nxt = r_q_inst[1];
    w_q1_pc_nxt   = r_q_pc[1];
    if (bus.redirect) begin
      w_count_nxt = 2'd0;
    end else begin
      case ({w_push, w_pop})
        2'b10: begin
          w_count_nxt = r_count + 2'd1;
          if (r_count == 2'd0) begin
            w_q0_inst_nxt = bus.mem_dout;
            w_q0_pc_nxt   = r_inflight_pc;
          end else begin
            w_q1_inst_nxt = bus.mem_dout;
            w_q1_pc_nxt   = r_inflight_pc;
          end
        end
        2'b01: begin
          w_count_nxt   = r_count - 2'd1;
          w_q0_inst_nxt = r_q_inst[1];
          w_q0_pc_nxt   = r_q_pc[1];
        end
        2'b11: begin
          if (r_count == 2'd1) begin
            w_q0_inst_nxt = bus.mem_dout;
            w_q0_pc_nxt   = r_inflight_pc;
          end else begin
            w_q0_inst_nxt = r_q_inst[1];
            w_q0_pc_nxt   = r_q_pc[1];
            w_q1_inst_nxt = bus.mem_dout;
            w_q1_pc_nxt   = r_inflight_pc;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_pc       <= RESET_PC;
      r_inflight <= 1'b0;
      r_count    <= 2'd0;
      r_valid    <= 1'b0;
      r_halted   <= 1'b0;
      r_q_inst[0] <= '0;
      r_q_pc[0]   <= '0;
      r_q_inst[1] <= '0;
      r_q_pc[1]   <= '0;
    end else begin
      r_count     <= w_count_nxt;
      r_valid     <= (w_count_nxt != 2'd0);
      r_q_inst[0] <= w_q0_inst_nxt;
      r_q_pc[0]   <= w_q0_pc_nxt;
      r_q_inst[1] <= w_q1_inst_nxt;
      r_q_pc[1]   <= w_q1_pc_nxt;
      r_inflight  <= w_issue;
      if (bus.redirect) begin
        r_pc     <= bus.redirect_addr;
        r_halted <= 1'b0;
      end else begin
        if (w_issue)
          r_pc <= r_pc + ADDR'(1);
`ifdef IFETCH_HALT_EN
        if (w_push && (bus.mem_dout == HALT_WORD))
          r_halted <= 1'b1;
`endif
      end
    end
  end

  // PC of the outstanding read; meaningless while r_inflight is low.
  always_ff @(posedge clk) begin
    if (w_issue)
      r_inflight_pc <= r_pc;
  end

  a_no_overflow: assert property (@(posedge clk) disable iff (rst)
    !(w_push && !w_pop && (r_count == 2'd2)));

endmodule

// File: tb/tb_inst_fetch.sv
// Directed bench for inst_fetch with a behavioural synchronous-read memory on port A.
module tb_inst_fetch;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_assert = 0;
  int   n_fail   = 0;
  logic [13:0] exp_pc;
  logic [17:0] mem [16384];

  inst_fetch_if #(.DATA(18), .ADDR(14)) bus ();

  inst_fetch #(.DATA(18), .ADDR(14), .RESET_PC(14'h0000)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) bus.mem_dout <= mem[bus.mem_addr];

  initial begin
    #2000000;
    $display("FAIL watchdog: observed timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_assert++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // Scoreboard: each accepted word must be the next expected address and its memory content.
  task automatic stream_chk();
    if (bus.inst_valid && bus.inst_ready) begin
      chk("stream_pc", 32'(bus.inst_pc), 32'(exp_pc));
      chk("stream_inst", 32'(bus.inst), 32'(mem[exp_pc]));
      exp_pc = exp_pc + 14'd1;
    end
  endtask

  initial begin
    for (int i = 0; i < 16384; i++) mem[i] = 18'(i);
    bus.redirect      = 1'b0;
    bus.redirect_addr = '0;
    bus.inst_ready    = 1'b1;
    exp_pc            = '0;

    // Reset state
    rst = 1'b1;
    tick();
    tick();
    chk("rst_valid", 32'(bus.inst_valid), 0);
    chk("rst_inst", 32'(bus.inst), 0);
    chk("rst_inst_pc", 32'(bus.inst_pc), 0);
    chk("rst_mem_addr", 32'(bus.mem_addr), 0);
    chk("mem_wr_const", 32'(bus.mem_wr), 0);
    chk("mem_din_const", 32'(bus.mem_din), 0);
`ifdef IFETCH_HALT_EN
    chk("rst_halted", 32'(bus.halted), 0);
`endif

    // Phase A: startup latency, 5-cycle stall from cycle 4, no gap on release
    rst = 1'b0;
    chk("A_c0_addr", 32'(bus.mem_addr), 0);
    chk("A_c0_valid", 32'(bus.inst_valid), 0);
    tick();
    chk("A_c1_addr", 32'(bus.mem_addr), 1);
    chk("A_c1_valid", 32'(bus.inst_valid), 0);
    tick();
    for (int c = 2; c <= 14; c++) begin
      bus.inst_ready = !(c >= 4 && c <= 8);
      chk("A_valid", 32'(bus.inst_valid), 1);
      if (c >= 5 && c <= 8) begin
        chk("A_stall_addr", 32'(bus.mem_addr), 4);
        chk("A_stall_head", 32'(bus.inst_pc), 2);
      end
      stream_chk();
      tick();
    end
    chk("A_delivered", 32'(exp_pc), 8);

    // Phase B: redirect to 0x1234 in cycle 6 while the queue is full
    bus.inst_ready = 1'b1;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    exp_pc = '0;
    for (int c = 0; c <= 12; c++) begin
      bus.inst_ready    = (c < 4) || (c >= 7);
      bus.redirect      = (c == 6);
      bus.redirect_addr = 14'h1234;
      if (c == 5 || c == 6) begin
        chk("B_full_valid", 32'(bus.inst_valid), 1);
        chk("B_full_head", 32'(bus.inst_pc), 2);
      end
      if (c == 7) chk("B_R1_addr", 32'(bus.mem_addr), 32'h1234);
      if (c == 7 || c == 8) chk("B_flush_valid", 32'(bus.inst_valid), 0);
      if (c == 9) begin
        chk("B_R3_valid", 32'(bus.inst_valid), 1);
        chk("B_R3_pc", 32'(bus.inst_pc), 32'h1234);
        chk("B_R3_inst", 32'(bus.inst), 32'h1234);
      end
      stream_chk();
      if (c == 6) exp_pc = 14'h1234;
      tick();
    end
    bus.redirect = 1'b0;
    chk("B_delivered", 32'(exp_pc), 32'h1238);

    // Phase C: redirect with a coincident pop, then address wrap
    for (int c = 0; c <= 7; c++) begin
      bus.inst_ready    = 1'b1;
      bus.redirect      = (c == 0);
      bus.redirect_addr = 14'h3FFE;
      if (c == 1 || c == 2) chk("C_flush_valid", 32'(bus.inst_valid), 0);
      if (c == 3) chk("C_pc_3FFE", 32'(bus.inst_pc), 32'h3FFE);
      if (c == 4) chk("C_pc_3FFF", 32'(bus.inst_pc), 32'h3FFF);
      if (c == 5) begin
        chk("C_wrap_pc", 32'(bus.inst_pc), 0);
        chk("C_wrap_inst", 32'(bus.inst), 0);
      end
      if (c == 6) chk("C_pc_1", 32'(bus.inst_pc), 1);
      stream_chk();
      if (c == 0) exp_pc = 14'h3FFE;
      tick();
    end
    bus.redirect = 1'b0;
    chk("C_delivered", 32'(exp_pc), 3);

    // Phase D: random back-pressure, then a 1-cycle reset mid-stream
    for (int c = 0; c < 30; c++) begin
      bus.inst_ready = 1'($urandom_range(0, 1));
      stream_chk();
      tick();
    end
    bus.inst_ready = 1'($urandom_range(0, 1));
    rst = 1'b1;
    tick();
    rst = 1'b0;
    bus.inst_ready = 1'b1;
    exp_pc = '0;
    chk("D_c0_valid", 32'(bus.inst_valid), 0);
    chk("D_c0_addr", 32'(bus.mem_addr), 0);
    tick();
    chk("D_c1_valid", 32'(bus.inst_valid), 0);
    tick();
    chk("D_c2_valid", 32'(bus.inst_valid), 1);
    chk("D_c2_pc", 32'(bus.inst_pc), 0);
    for (int c = 2; c <= 6; c++) begin
      stream_chk();
      tick();
    end
    chk("D_delivered", 32'(exp_pc), 5);

`ifdef IFETCH_HALT_EN
    // Phase E: halt word at address 5, then a redirect to 0 resumes fetch
    mem[5] = 18'h3FFFF;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    exp_pc = '0;
    for (int c = 0; c <= 16; c++) begin
      bus.inst_ready    = 1'b1;
      bus.redirect      = (c == 12);
      bus.redirect_addr = 14'h0000;
      if (c == 6) chk("E_not_yet_halted", 32'(bus.halted), 0);
      if (c == 7) begin
        chk("E_halted", 32'(bus.halted), 1);
        chk("E_halt_pc", 32'(bus.inst_pc), 5);
        chk("E_halt_inst", 32'(bus.inst), 32'h3FFFF);
      end
      if (c >= 8 && c <= 12) begin
        chk("E_frozen_addr", 32'(bus.mem_addr), 7);
        chk("E_frozen_valid", 32'(bus.inst_valid), 0);
        chk("E_still_halted", 32'(bus.halted), 1);
      end
      if (c == 13) begin
        chk("E_cleared", 32'(bus.halted), 0);
        chk("E_resume_addr", 32'(bus.mem_addr), 0);
      end
      if (c == 15) chk("E_resume_pc", 32'(bus.inst_pc), 0);
      stream_chk();
      if (c == 12) exp_pc = '0;
      tick();
    end
    bus.redirect = 1'b0;
    chk("E_delivered", 32'(exp_pc), 2);
    mem[5] = 18'd5;
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule

// File: doc/inst_fetch.md
# inst_fetch

Instruction fetch stage sitting directly upstream of the decode logic and driving read port A of the shared dual-port instruction/data memory (synchronous read, 1-cycle latency, no read enable). Generates sequential PCs, tracks the in-flight read, buffers returned words in a 2-entry queue, and presents them to decode over a valid/ready handshake. A redirect input (branch/jump) flushes all buffered and in-flight words and restarts fetch at a new address.

## Interface
- DATA, 18, instruction word width; must match the memory's DATA.
- ADDR, 14, address width; must match the memory's ADDR.
- RESET_PC, 0, fetch address after reset.
- HALT_WORD, all ones (18'h3FFFF), halt encoding; used only with IFETCH_HALT_EN.

- clk  in  1  clock; rising edge, shared with memory port A.
- rst  in  1  synchronous, active-high reset.
- mem_addr  out  ADDR  memory port A address; driven combinationally from the PC register.
- mem_wr  out  1  memory port A write strobe; constant 0.
- mem_din  out  DATA  memory port A write data; constant 0.
- mem_dout  in  DATA  memory port A read data, valid the cycle after the address is presented.
- redirect  in  1  one-cycle pulse: flush and restart at redirect_addr.
- redirect_addr  in  ADDR  new fetch address, sampled when redirect=1.
- inst_valid  out  1  queue head holds a valid instruction.
- inst_ready  in  1  decode accepts the head this cycle.
- inst  out  DATA  instruction at queue head.
- inst_pc  out  ADDR  address the head instruction was fetched from.
- halted  out  1  fetch stopped on HALT_WORD; present only with IFETCH_HALT_EN.

## Operation
- State: pc (ADDR), inflight (1), inflight_pc (ADDR), 2-entry queue of {inst, pc} with count 0..2.
- pop = inst_valid & inst_ready.
- issue = !redirect & (count + inflight - pop < 2); without the halt feature there is no other condition. When issue=1 the current pc is on mem_addr; pc <= pc+1 modulo 2**ADDR, so 2**ADDR-1 wraps to 0.
- inflight <= issue; inflight_pc <= pc when issue=1.
- When inflight=1 and no redirect, push {mem_dout, inflight_pc} into the queue.
- Push and pop in the same cycle: count is unchanged and order is preserved.
- The credit rule makes overflow impossible; a push into a full queue is a design error and is asserted in simulation.
- redirect=1 (takes priority over everything):
  - queue count <= 0, inflight <= 0; the word returning this cycle is discarded.
  - No issue this cycle; pc <= redirect_addr.
  - A pop coincident with redirect still completes for decode, since decode issued it before seeing the redirect.
- inst and inst_pc always reflect the queue head; they are don't-care when inst_valid=0, but driven stable from registers.
- Reset: pc=RESET_PC, inflight=0, count=0, inst_valid=0, inst=0, inst_pc=0, halted=0. Reset mid-stream drops all queued and in-flight words.

## Timing
- Reset released before cycle 0:
  - cycle 0: mem_addr=RESET_PC.
  - cycle 1: word captured at the end of the cycle.
  - cycle 2: inst_valid=1 first.
- Redirect in cycle R:
  - R+1: mem_addr=redirect_addr.
  - R+3: inst_valid with inst_pc=redirect_addr.
- Steady state with inst_ready held 1: one instruction per cycle, consecutive inst_pc values.
- inst_ready low: at most 2 words are held and fetch stalls; no word is lost or duplicated.
- On re-assertion, throughput returns to 1/cycle with no bubble while the queue is non-empty.
- Outputs are registered except mem_addr (comb from pc) and mem_wr/mem_din (constants).

## Configuration
- IFETCH_HALT_EN defined:
  - Adds the halted output.
  - When the pushed word equals HALT_WORD, halted <= 1; the word is still queued and delivered.
  - While halted=1, issue=0; any word returning in the next cycle is discarded.
  - halted clears only on redirect or rst.
- IFETCH_HALT_EN undefined: no halted port; HALT_WORD is ignored and fetch is continuous.

## Test plan
- Reset release, memory preloaded mem[i]=i, inst_ready=1 -> inst_valid rises in cycle 2; inst/inst_pc = 0,1,2,3… one per cycle.
- inst_ready=0 for 5 cycles from cycle 4 -> count saturates at 2 and mem_addr holds; on release the sequence continues with no gap, loss or duplicate.
- redirect to 0x1234 in cycle 6 while the queue is full -> inst_valid=0 in R+1 and R+2; R+3 gives inst_pc=0x1234, inst=mem[0x1234]; no stale word ever appears.
- redirect to 0x3FFE -> PCs 0x3FFE, 0x3FFF, 0x0000, 0x0001 (wrap).
- rst asserted for 1 cycle mid-stream with a random inst_ready pattern -> next cycle inst_valid=0; restart at RESET_PC with the cycle-2 latency.
- IFETCH_HALT_EN, mem[5]=18'h3FFFF -> PCs 0..5 delivered; halted=1; mem_addr frozen; a later redirect to 0 clears halted and fetch resumes.
